// File: rtl/pmic_pkg.sv
// Shared definitions for the PMIC power-up init sequencer.
// Holds the layout of a 24-bit table entry, the op encodings, the FSM state type,
// the PMIC register map used by the init table, and a helper that packs entries.
package pmic_pkg;

  // Table entry layout: {op, addr[6:0], data[7:0], mask[7:0]}
  localparam int ENTRY_W  = 24;
  localparam int OP_BIT   = 23;
  localparam int ADDR_MSB = 22;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 8;
  localparam int MASK_MSB = 7;
  localparam int MASK_LSB = 0;

  // Operation encodings (entry bit OP_BIT)
  localparam logic OP_WRITE  = 1'b0;
  localparam logic OP_VERIFY = 1'b1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RETRY = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FAIL  = 3'd7
  } state_t;

  // PMIC register map touched by the init table
  localparam logic [6:0] REG_DEVICE_ID  = 7'h05;
  localparam logic [6:0] REG_BUCK1_CTRL = 7'h12;
  localparam logic [6:0] REG_LDO1_VSEL  = 7'h20;
  localparam logic [6:0] REG_LDO1_CTRL  = 7'h21;
  localparam logic [6:0] REG_BUCK2_VSEL = 7'h30;
  localparam logic [6:0] REG_BUCK2_CTRL = 7'h31;
  localparam logic [6:0] REG_GPIO_CFG   = 7'h40;
  localparam logic [6:0] REG_WDT_CFG    = 7'h41;

  // Pack one table entry; the mask is only meaningful for verify entries.
  function automatic logic [ENTRY_W-1:0] mk_entry(
    input logic       op,
    input logic [6:0] addr,
    input logic [7:0] data,
    input logic [7:0] mask
  );
    logic [ENTRY_W-1:0] e;
    e                     = '0;
    e[OP_BIT]             = op;
    e[ADDR_MSB:ADDR_LSB]  = addr;
    e[DATA_MSB:DATA_LSB]  = data;
    e[MASK_MSB:MASK_LSB]  = mask;
    return e;
  endfunction

endpackage

// File: rtl/pmic_init_rom.sv
// Purpose : fixed PMIC init table, index -> 24-bit entry {op, addr, data, mask}.
// Latency : combinational, no state.
// Backpressure: none; pure lookup.
// Ports   : index_i - table index (0..15); entry_o - packed entry for that index.
//           Unused indices return a write of 0x00 to address 0x00.
module pmic_init_rom
  import pmic_pkg::*;
(
  input  logic [3:0]         index_i,
  output logic [ENTRY_W-1:0] entry_o
);

  always_comb begin
    entry_o = mk_entry(OP_WRITE, 7'h00, 8'h00, 8'h00);
    case (index_i)
      4'd0:    entry_o = mk_entry(OP_WRITE,  REG_BUCK1_CTRL, 8'h34, 8'h00);
      4'd1:    entry_o = mk_entry(OP_WRITE,  REG_LDO1_VSEL,  8'h01, 8'h00);
      4'd2:    entry_o = mk_entry(OP_WRITE,  REG_LDO1_CTRL,  8'h80, 8'h00);
      4'd3:    entry_o = mk_entry(OP_WRITE,  REG_BUCK2_VSEL, 8'h0F, 8'h00);
      4'd4:    entry_o = mk_entry(OP_WRITE,  REG_BUCK2_CTRL, 8'h55, 8'h00);
      4'd5:    entry_o = mk_entry(OP_WRITE,  REG_GPIO_CFG,   8'h03, 8'h00);
      4'd6:    entry_o = mk_entry(OP_WRITE,  REG_WDT_CFG,    8'hC8, 8'h00);
      // Only the upper nibble of the ID register identifies the part family.
      4'd7:    entry_o = mk_entry(OP_VERIFY, REG_DEVICE_ID,  8'hA0, 8'hF0);
      default: entry_o = mk_entry(OP_WRITE,  7'h00,          8'h00, 8'h00);
    endcase
  end

endmodule

// File: rtl/pmic_init_sequencer.sv
// Purpose : walks the PMIC init table, issuing one wishbone_handler transaction per
//           entry (write or read-and-verify), with per-entry timeout and retries.
// Latency : per passing entry ISSUE(1) + handler time + CHECK(1) + NEXT(1); o_begin
//           rises the cycle after an accepted i_start.
// Backpressure: one transaction outstanding; waits for i_done (or timeout) before
//           the next o_begin. i_start is ignored while busy.
// Ports   : i_clk/i_reset (sync, active-high); i_start; o_busy/o_ok/o_error/
//           o_errIndex status; o_begin/o_writeEnable/o_address/o_writeData request
//           to the handler; i_done/i_readData completion from the handler.
module pmic_init_sequencer
  import pmic_pkg::*;
#(
  parameter int NUM_ENTRIES    = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_ok,
  output logic       o_error,
  output logic [3:0] o_errIndex,
  output logic       o_begin,
  output logic       o_writeEnable,
  output logic [6:0] o_address,
  output logic [7:0] o_writeData,
  input  logic       i_done,
  input  logic [7:0] i_readData
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;

  localparam logic [3:0]       LAST_IDX  = 4'(NUM_ENTRIES - 1);
  // Loaded in ISSUE and counted down in WAIT; zero is seen exactly
  // TIMEOUT_CYCLES cycles after the ISSUE cycle.
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);

  state_t             state_q;
  logic [3:0]         idx_q;
  logic [3:0]         idx_d;
  logic [RTY_W-1:0]   rty_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [7:0]         rdata_q;
  logic               busy_q;
  logic               ok_q;
  logic               error_q;
  logic [3:0]         err_idx_q;
  logic               begin_q;
  logic               we_q;
  logic [6:0]         addr_q;
  logic [7:0]         wdata_q;

  logic [ENTRY_W-1:0] entry;
  logic               ent_op;
  logic [6:0]         ent_addr;
  logic [7:0]         ent_data;
  logic [7:0]         ent_mask;
  logic               issue_we;
  logic [7:0]         issue_wdata;
  logic               check_pass;

  // The request fields are registered on the edge that enters ISSUE so they line
  // up with o_begin. That edge is also where the index advances, so the ROM is
  // addressed with the next index rather than the current one.
  always_comb begin
    idx_d = idx_q;
    case (state_q)
      ST_IDLE: if (i_start) idx_d = 4'd0;
      ST_NEXT: if (idx_q != LAST_IDX) idx_d = idx_q + 4'd1;
      default: ;
    endcase
  end

  pmic_init_rom u_rom (
    .index_i (idx_d),
    .entry_o (entry)
  );

  assign ent_op      = entry[OP_BIT];
  assign ent_addr    = entry[ADDR_MSB:ADDR_LSB];
  assign ent_data    = entry[DATA_MSB:DATA_LSB];
  assign ent_mask    = entry[MASK_MSB:MASK_LSB];
  assign issue_we    = (ent_op == OP_WRITE);
  assign issue_wdata = (ent_op == OP_VERIFY) ? 8'h00 : ent_data;

  // In CHECK idx_d equals idx_q, so the ROM is showing the entry being checked.
  assign check_pass  = (ent_op == OP_WRITE) ||
                       ((rdata_q & ent_mask) == (ent_data & ent_mask));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      rty_q     <= '0;
      tmo_q     <= '0;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      ok_q      <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= 4'd0;
      begin_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
    end else begin
      // o_begin is a one-cycle pulse; only transitions into ISSUE raise it.
      begin_q <= 1'b0;
      idx_q   <= idx_d;

      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            ok_q    <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            rty_q   <= '0;
            begin_q <= 1'b1;
            we_q    <= issue_we;
            addr_q  <= ent_addr;
            wdata_q <= issue_wdata;
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_q   <= TMO_LOAD;
          state_q <= ST_WAIT;
        end

        // A done arriving in the same cycle the counter hits zero takes priority.
        ST_WAIT: begin
          if (i_done) begin
            rdata_q <= i_readData;
            state_q <= ST_CHECK;
          end else if (tmo_q == '0) begin
            state_q <= ST_RETRY;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end

        ST_CHECK: begin
          state_q <= check_pass ? ST_NEXT : ST_RETRY;
        end

        ST_RETRY: begin
          if (rty_q < RTY_LIMIT) begin
            rty_q   <= rty_q + 1'b1;
            begin_q <= 1'b1;
            we_q    <= issue_we;
            addr_q  <= ent_addr;
            wdata_q <= issue_wdata;
            state_q <= ST_ISSUE;
          end else begin
            // Status flips on the edge into FAIL so busy falls as error rises.
            err_idx_q <= idx_q;
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_FAIL;
          end
        end

        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            ok_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            rty_q   <= '0;
            begin_q <= 1'b1;
            we_q    <= issue_we;
            addr_q  <= ent_addr;
            wdata_q <= issue_wdata;
            state_q <= ST_ISSUE;
          end
        end

        ST_DONE: state_q <= ST_IDLE;
        ST_FAIL: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_ok          = ok_q;
  assign o_error       = error_q;
  assign o_errIndex    = err_idx_q;
  assign o_begin       = begin_q;
  assign o_writeEnable = we_q;
  assign o_address     = addr_q;
  assign o_writeData   = wdata_q;

endmodule

// File: doc/pmic_init_sequencer.md
Name: pmic_init_sequencer

Overview:
- Upstream command source for wishbone_handler.
- On a start pulse it walks a fixed table of PMIC register operations and issues one wishbone_handler transaction per entry. Each operation is either a write or a read-and-verify.
- Each transaction is a begin pulse followed by waiting for done.
- Reports overall pass/fail and the index of the first failing entry.
- Sits between the board power-up controller and wishbone_handler.

Parameters:
- NUM_ENTRIES, 8, number of table entries (1..16).
- TIMEOUT_CYCLES, 4096, maximum i_clk cycles to wait for i_done after o_begin.
- MAX_RETRIES, 2, extra attempts per entry after a timeout or verify mismatch.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle pulse; starts the sequence; ignored unless idle.
- o_busy  out  1  high from the cycle after an accepted i_start until DONE/FAIL is entered.
- o_ok  out  1  sticky; high after the sequence completes without error; cleared by the next accepted i_start.
- o_error  out  1  sticky; high after a failure; cleared by the next accepted i_start.
- o_errIndex  out  4  index of the failing entry; valid while o_error is high.
- o_begin  out  1  one-cycle transaction request to wishbone_handler.
- o_writeEnable  out  1  1 = write, 0 = read; held stable from o_begin until i_done.
- o_address  out  7  register address; held stable from o_begin until i_done.
- o_writeData  out  8  write data; held stable from o_begin until i_done.
- i_done  in  1  one-cycle completion pulse from wishbone_handler.
- i_readData  in  8  read result; valid in the i_done cycle.

Behaviour:
- Reset values:
  - state IDLE.
  - o_busy, o_ok, o_error, o_begin, o_writeEnable = 0.
  - o_address, o_writeData, o_errIndex = 0.
  - index and retry counters = 0.
- Table entry, 24 bits: op[23] (0 write, 1 verify), addr[22:16], data[15:8], mask[7:0]. Provided combinationally by the ROM sub-module from the current index.
- States and transitions:
  - IDLE: on i_start, clear o_ok/o_error, index=0, retry=0 → ISSUE.
  - ISSUE: for exactly one cycle, drive o_begin=1, o_address=addr, o_writeEnable=~op, and o_writeData=data (0 for verify). Load the timeout counter → WAIT.
  - WAIT:
    - If i_done: capture i_readData → CHECK.
    - Else if the timeout counter reaches 0 → RETRY.
    - The counter decrements once per cycle, so the timeout fires TIMEOUT_CYCLES cycles after the ISSUE cycle.
  - CHECK:
    - Write entries pass unconditionally.
    - Verify entries pass when (readData & mask) == (data & mask).
    - Pass → NEXT; fail → RETRY.
  - RETRY:
    - If retry < MAX_RETRIES: retry++ → ISSUE.
    - Else: o_errIndex=index → FAIL.
  - NEXT:
    - If index == NUM_ENTRIES-1 → DONE.
    - Else index++, retry=0 → ISSUE.
  - DONE: o_ok=1, o_busy=0 → IDLE.
  - FAIL: o_error=1, o_busy=0 → IDLE.
- Latency per successful entry: ISSUE (1) + WAIT (handler time) + CHECK (1) + NEXT (1). No back-to-back o_begin pulses: there are at least 3 cycles between an i_done and the next o_begin.
- i_start while busy: ignored; the sequence is not restarted.
- i_done outside WAIT: ignored, including a late done arriving after a timeout.
- i_done in the same cycle the timeout expires: i_done wins and goes to CHECK.
- i_reset mid-sequence:
  - Immediate return to IDLE with all outputs at reset values.
  - o_begin is never asserted in the reset cycle.
  - Any in-flight handler transaction is abandoned.
- Widths:
  - Index counter: 4 bits.
  - Retry counter: 2 bits minimum, sized for MAX_RETRIES.
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package (pmic_pkg) holds:
  - Entry field positions OP_BIT, ADDR_MSB/LSB, DATA_MSB/LSB, MASK_MSB/LSB.
  - OP_WRITE/OP_VERIFY constants.
  - State encodings.
  - PMIC register address constants used by the table.
- Sub-module pmic_init_rom: combinational case-statement ROM, index → 24-bit entry. Unused indices return a write of 0x00 to address 0x00.

Test Plan:
- Write-only table with a handler model returning i_done 10 cycles after o_begin:
  - First transaction has o_address=7'h12, o_writeData=8'h34, o_writeEnable=1.
  - NUM_ENTRIES o_begin pulses total, each exactly 1 cycle.
  - o_ok=1 and o_busy=0 at the end.
- Verify entry (addr 7'h05, data 8'hA0, mask 8'hF0) with the model returning 8'hA7: passes, o_writeEnable=0, no retries.
- Same verify entry with the model returning 8'hB0:
  - Exactly MAX_RETRIES+1 o_begin pulses for that entry.
  - Then o_error=1 and o_errIndex equals that entry's index.
- Model never asserts done:
  - Each attempt times out TIMEOUT_CYCLES cycles after ISSUE.
  - 3 attempts total, then o_error=1.
  - A late i_done pulse afterwards changes nothing.
- i_start pulsed while busy → sequence unaffected. i_reset asserted during WAIT on entry 3 → next cycle all outputs are 0 and state is IDLE. A fresh i_start then restarts from entry 0.
- i_done and timeout expiry in the same cycle → CHECK is taken and the entry passes with no retry.
